// File: rtl/sram_req_arbiter.sv
// Request arbiter in front of the ZBT SRAM controller: one write client and two read clients
// share one request port, and a tag FIFO routes in-order read data back to its owner.
module sram_req_arbiter #(
    parameter int unsigned addr_width   = 18,
    parameter int unsigned data_width   = 32,
    parameter int unsigned TAG_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  wr_req_valid,
    input  logic [addr_width-1:0] wr_req_addr,
    input  logic [data_width-1:0] wr_req_data,
    output logic                  wr_req_ready,
    input  logic                  rd0_req_valid,
    input  logic [addr_width-1:0] rd0_req_addr,
    output logic                  rd0_req_ready,
    output logic                  rd0_resp_valid,
    input  logic                  rd0_resp_ready,
    input  logic                  rd1_req_valid,
    input  logic [addr_width-1:0] rd1_req_addr,
    output logic                  rd1_req_ready,
    output logic                  rd1_resp_valid,
    input  logic                  rd1_resp_ready,
    output logic [data_width-1:0] resp_data,
    output logic [addr_width-1:0] sram_rd_addr,
    output logic                  sram_rd_en,
    input  logic                  sram_rd_rdy,
    input  logic [data_width-1:0] sram_dout,
    input  logic                  sram_dout_rdy,
    output logic                  sram_dout_en,
    output logic [addr_width-1:0] sram_wr_addr,
    output logic [data_width-1:0] sram_wr_val,
    output logic                  sram_wr_en
);

    localparam int unsigned PtrW = $clog2(TAG_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

    logic [TAG_DEPTH-1:0] tag_mem_q;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      tag_cnt_q, tag_cnt_d;
    logic [StW-1:0]       starve_q, starve_d;
    logic                 rr_last_q;

    logic rd_ok, force_rd, wr_gnt, rd_gnt, rd_sel;
    logic tag_full, tag_nonempty, head;
    logic push, pop;

    always_comb begin
        wr_gnt       = 1'b0;
        rd_gnt       = 1'b0;
        rd_sel       = 1'b0;
        tag_full     = (tag_cnt_q == CntW'(TAG_DEPTH));
        tag_nonempty = (tag_cnt_q != '0);
        head         = tag_mem_q[rd_ptr_q];

        rd_ok    = RST_N & sram_rd_rdy & ~tag_full & (rd0_req_valid | rd1_req_valid);
        force_rd = rd_ok & (starve_q == StW'(STARVE_LIMIT));
        wr_gnt   = RST_N & wr_req_valid & ~force_rd;
        rd_gnt   = ~wr_gnt & rd_ok;

        // On a tie the client that did not win last time goes next
        if (rd0_req_valid && rd1_req_valid) begin
            rd_sel = ~rr_last_q;
        end else begin
            rd_sel = rd1_req_valid;
        end

        wr_req_ready  = wr_gnt;
        sram_wr_en    = wr_gnt;
        sram_wr_addr  = wr_req_addr;
        sram_wr_val   = wr_req_data;

        sram_rd_en    = rd_gnt;
        sram_rd_addr  = rd_sel ? rd1_req_addr : rd0_req_addr;
        rd0_req_ready = rd_gnt & ~rd_sel;
        rd1_req_ready = rd_gnt & rd_sel;

        rd0_resp_valid = RST_N & sram_dout_rdy & tag_nonempty & ~head;
        rd1_resp_valid = RST_N & sram_dout_rdy & tag_nonempty & head;
        resp_data      = sram_dout;
        sram_dout_en   = (rd0_resp_valid & rd0_resp_ready) | (rd1_resp_valid & rd1_resp_ready);

        push = rd_gnt;
        pop  = sram_dout_en;

        tag_cnt_d = tag_cnt_q;
        unique case ({push, pop})
            2'b10:   tag_cnt_d = tag_cnt_q + CntW'(1);
            2'b01:   tag_cnt_d = tag_cnt_q - CntW'(1);
            default: tag_cnt_d = tag_cnt_q;
        endcase

        starve_d = starve_q;
        if (rd_gnt || !rd_ok) begin
            starve_d = '0;
        end else if (wr_gnt && (starve_q != StW'(STARVE_LIMIT))) begin
            starve_d = starve_q + StW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tag_mem_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_cnt_q <= '0;
            starve_q  <= '0;
            rr_last_q <= 1'b1;
        end else begin
            if (push) begin
                tag_mem_q[wr_ptr_q] <= rd_sel;
                wr_ptr_q            <= wr_ptr_q + PtrW'(1);
                rr_last_q           <= rd_sel;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            tag_cnt_q <= tag_cnt_d;
            starve_q  <= starve_d;
        end
    end

    // Read data with no outstanding tag means the controller and arbiter have lost sync
    assert property (@(posedge CLK) disable iff (!RST_N) !(sram_dout_rdy && !tag_nonempty));

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: controller model, queue-based reference checker, vector table,
// directed corner-case sequences and randomized traffic.
module tb_sram_req_arbiter;

    localparam int AW = 18;
    localparam int DW = 32;
    localparam int TD = 4;
    localparam int SL = 8;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          wr_req_valid = 1'b0;
    logic [AW-1:0] wr_req_addr = '0;
    logic [DW-1:0] wr_req_data = '0;
    logic          wr_req_ready;
    logic          rd0_req_valid = 1'b0;
    logic [AW-1:0] rd0_req_addr = '0;
    logic          rd0_req_ready;
    logic          rd0_resp_valid;
    logic          rd0_resp_ready = 1'b1;
    logic          rd1_req_valid = 1'b0;
    logic [AW-1:0] rd1_req_addr = '0;
    logic          rd1_req_ready;
    logic          rd1_resp_valid;
    logic          rd1_resp_ready = 1'b1;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] sram_rd_addr;
    logic          sram_rd_en;
    logic          sram_rd_rdy = 1'b1;
    logic [DW-1:0] sram_dout = '0;
    logic          sram_dout_rdy = 1'b0;
    logic          sram_dout_en;
    logic [AW-1:0] sram_wr_addr;
    logic [DW-1:0] sram_wr_val;
    logic          sram_wr_en;

    always #5 CLK = ~CLK;

    sram_req_arbiter #(
        .addr_width  (AW),
        .data_width  (DW),
        .TAG_DEPTH   (TD),
        .STARVE_LIMIT(SL)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .wr_req_valid  (wr_req_valid),
        .wr_req_addr   (wr_req_addr),
        .wr_req_data   (wr_req_data),
        .wr_req_ready  (wr_req_ready),
        .rd0_req_valid (rd0_req_valid),
        .rd0_req_addr  (rd0_req_addr),
        .rd0_req_ready (rd0_req_ready),
        .rd0_resp_valid(rd0_resp_valid),
        .rd0_resp_ready(rd0_resp_ready),
        .rd1_req_valid (rd1_req_valid),
        .rd1_req_addr  (rd1_req_addr),
        .rd1_req_ready (rd1_req_ready),
        .rd1_resp_valid(rd1_resp_valid),
        .rd1_resp_ready(rd1_resp_ready),
        .resp_data     (resp_data),
        .sram_rd_addr  (sram_rd_addr),
        .sram_rd_en    (sram_rd_en),
        .sram_rd_rdy   (sram_rd_rdy),
        .sram_dout     (sram_dout),
        .sram_dout_rdy (sram_dout_rdy),
        .sram_dout_en  (sram_dout_en),
        .sram_wr_addr  (sram_wr_addr),
        .sram_wr_val   (sram_wr_val),
        .sram_wr_en    (sram_wr_en)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 'h10) return 32'hDEADBEEF;
        return 32'hC0DE0000 ^ a;
    endfunction

    // Controller model: 3-cycle read pipeline, holds DOUT until DOUT_EN
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } pend_t;
    pend_t         pq[$];
    logic [DW-1:0] cmem[int];
    int            cyc = 0;

    always @(posedge CLK) begin
        if (!RST_N) begin
            pq.delete();
        end else begin
            if (sram_dout_en) begin
                check("ctrl_pop_has_data", (pq.size() > 0 && pq[0].due <= cyc), 1);
                if (pq.size() > 0) void'(pq.pop_front());
            end
            if (sram_wr_en) cmem[int'(sram_wr_addr)] = sram_wr_val;
            if (sram_rd_en) begin
                check("ctrl_rd_when_rdy", sram_rd_rdy, 1);
                pq.push_back('{cmem.exists(int'(sram_rd_addr)) ? cmem[int'(sram_rd_addr)]
                                                               : init_word(int'(sram_rd_addr)),
                               cyc + 2});
            end
        end
        sram_dout_rdy <= (pq.size() > 0) && (pq[0].due <= cyc);
        sram_dout     <= (pq.size() > 0) ? pq[0].data : '0;
        cyc++;
    end

    // Reference: owner/data queue of outstanding reads, evaluated mid-cycle
    typedef struct {
        bit            owner;
        logic [DW-1:0] data;
    } tag_t;
    tag_t          tq[$];
    logic [DW-1:0] rmem[int];
    int            starve = 0;
    int            rr_last = 1;

    always @(negedge CLK) begin : ref_model
        bit            rd_ok, frc, e_wr, e_rd, e_v0, e_v1, e_den, own;
        logic [AW-1:0] sa;
        rd_ok = RST_N && sram_rd_rdy && (tq.size() < TD) && (rd0_req_valid || rd1_req_valid);
        frc   = rd_ok && (starve == SL);
        e_wr  = RST_N && wr_req_valid && !frc;
        e_rd  = !e_wr && rd_ok;
        if (rd0_req_valid && rd1_req_valid) own = (rr_last == 0);
        else own = rd1_req_valid;
        sa    = own ? rd1_req_addr : rd0_req_addr;
        e_v0  = RST_N && sram_dout_rdy && (tq.size() > 0) && (tq[0].owner == 1'b0);
        e_v1  = RST_N && sram_dout_rdy && (tq.size() > 0) && (tq[0].owner == 1'b1);
        e_den = (e_v0 && rd0_resp_ready) || (e_v1 && rd1_resp_ready);
        if (chk_en) begin
            check("wr_req_ready", wr_req_ready, e_wr);
            check("sram_wr_en", sram_wr_en, e_wr);
            check("sram_rd_en", sram_rd_en, e_rd);
            check("rd0_req_ready", rd0_req_ready, e_rd && !own);
            check("rd1_req_ready", rd1_req_ready, e_rd && own);
            check("rd0_resp_valid", rd0_resp_valid, e_v0);
            check("rd1_resp_valid", rd1_resp_valid, e_v1);
            check("sram_dout_en", sram_dout_en, e_den);
            if (e_rd) check("sram_rd_addr", sram_rd_addr, sa);
            if (e_wr) check("sram_wr_addr_val", {sram_wr_addr, sram_wr_val},
                            {wr_req_addr, wr_req_data});
            if (e_den) check("resp_data", resp_data, tq[0].data);
        end
        if (!RST_N) begin
            tq.delete();
            starve  = 0;
            rr_last = 1;
        end else begin
            if (e_den) void'(tq.pop_front());
            if (e_rd) begin
                tq.push_back('{own, rmem.exists(int'(sa)) ? rmem[int'(sa)] : init_word(int'(sa))});
                rr_last = own ? 1 : 0;
            end
            if (e_rd || !rd_ok) starve = 0;
            else if (e_wr && starve < SL) starve++;
            if (e_wr) rmem[int'(wr_req_addr)] = wr_req_data;
        end
    end

    typedef struct {
        bit       rst;
        bit       wr;
        bit       r0;
        bit       r1;
        bit       rdy;
        bit [4:0] exp;  // {wr_req_ready, rd0_req_ready, rd1_req_ready, sram_rd_en, sram_wr_en}
    } vec_t;

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        wr_req_valid   = 1'b0;
        rd0_req_valid  = 1'b0;
        rd1_req_valid  = 1'b0;
        rd0_resp_ready = 1'b1;
        rd1_resp_ready = 1'b1;
        sram_rd_rdy    = 1'b1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        idle_inputs();
        nxt();
        RST_N = 1'b1;
    endtask

    task automatic wait_resp(input bit client, output int lat);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (client ? rd1_resp_valid : rd0_resp_valid) begin
                lat = k;
                break;
            end
            nxt();
        end
    endtask

    task automatic drain(input int n);
        idle_inputs();
        repeat (n) nxt();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[9];
        int   lat;
        int   order[4];
        int   got;
        vt[0] = '{1, 0, 0, 0, 1, 5'b00000};
        vt[1] = '{1, 1, 0, 0, 1, 5'b10001};
        vt[2] = '{1, 0, 1, 0, 1, 5'b01010};
        vt[3] = '{1, 0, 0, 1, 1, 5'b00110};
        vt[4] = '{1, 0, 1, 1, 1, 5'b01010};
        vt[5] = '{1, 1, 1, 1, 1, 5'b10001};
        vt[6] = '{1, 0, 1, 1, 0, 5'b00000};
        vt[7] = '{1, 1, 1, 0, 0, 5'b10001};
        vt[8] = '{0, 1, 1, 1, 1, 5'b00000};

        idle_inputs();
        nxt();
        nxt();
        RST_N  = 1'b1;
        chk_en = 1'b1;

        // Single-cycle grant decisions from the reset state
        wr_req_addr  = 18'h5;
        wr_req_data  = 32'hA0A0_0005;
        rd0_req_addr = 18'h1;
        rd1_req_addr = 18'h2;
        for (int i = 0; i < 9; i++) begin
            do_reset();
            RST_N         = vt[i].rst;
            wr_req_valid  = vt[i].wr;
            rd0_req_valid = vt[i].r0;
            rd1_req_valid = vt[i].r1;
            sram_rd_rdy   = vt[i].rdy;
            @(negedge CLK);
            check($sformatf("vec%0d", i),
                  {wr_req_ready, rd0_req_ready, rd1_req_ready, sram_rd_en, sram_wr_en}, vt[i].exp);
            nxt();
            idle_inputs();
            RST_N = 1'b1;
        end

        // Single rd0 read, 3-cycle return
        do_reset();
        rd0_req_valid = 1'b1;
        rd0_req_addr  = 18'h00010;
        @(negedge CLK);
        check("t1_rd0_ready", rd0_req_ready, 1);
        nxt();
        rd0_req_valid = 1'b0;
        wait_resp(1'b0, lat);
        check("t1_latency", lat, 3);
        check("t1_data", resp_data, 32'hDEADBEEF);
        check("t1_rd1_quiet", rd1_resp_valid, 0);
        nxt();
        drain(6);

        // Both readers continuously valid alternate
        do_reset();
        rd0_req_valid = 1'b1;
        rd0_req_addr  = 18'h100;
        rd1_req_valid = 1'b1;
        rd1_req_addr  = 18'h200;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check($sformatf("t2_grant%0d", i), {rd0_req_ready, rd1_req_ready},
                  (i % 2 == 0) ? 2'b10 : 2'b01);
            nxt();
        end
        drain(10);

        // Write flood with a waiting read: one forced read per STARVE_LIMIT writes
        do_reset();
        wr_req_valid  = 1'b1;
        wr_req_addr   = 18'h20;
        wr_req_data   = 32'h0BAD_F00D;
        rd0_req_valid = 1'b1;
        rd0_req_addr  = 18'h30;
        for (int i = 0; i < 2 * (SL + 1); i++) begin
            @(negedge CLK);
            check($sformatf("t3_cycle%0d", i), {wr_req_ready, rd0_req_ready},
                  (i % (SL + 1) == SL) ? 2'b01 : 2'b10);
            nxt();
        end
        drain(10);

        // Fill the tag FIFO behind a stalled rd0 head; writes still flow
        do_reset();
        rd0_resp_ready = 1'b0;
        rd0_req_valid  = 1'b1;
        rd0_req_addr   = 18'h40;
        rd1_req_valid  = 1'b1;
        rd1_req_addr   = 18'h41;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check($sformatf("t4_issue%0d", i), {rd0_req_ready, rd1_req_ready},
                  (i % 2 == 0) ? 2'b10 : 2'b01);
            nxt();
        end
        wr_req_valid = 1'b1;
        wr_req_addr  = 18'h42;
        wr_req_data  = 32'h4242_4242;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check($sformatf("t4_full%0d", i), {wr_req_ready, rd0_req_ready, rd1_req_ready},
                  3'b100);
            nxt();
        end
        wr_req_valid   = 1'b0;
        rd0_req_valid  = 1'b0;
        rd1_req_valid  = 1'b0;
        rd0_resp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && got < 4; k++) begin
            @(negedge CLK);
            if (rd0_resp_valid && rd0_resp_ready) begin
                order[got] = 0;
                got++;
            end else if (rd1_resp_valid && rd1_resp_ready) begin
                order[got] = 1;
                got++;
            end
            nxt();
        end
        check("t4_drained", got, 4);
        for (int j = 0; j < got; j++) check($sformatf("t4_order%0d", j), order[j], j % 2);
        drain(4);

        // Read after write of the same word
        do_reset();
        wr_req_valid = 1'b1;
        wr_req_addr  = 18'h3;
        wr_req_data  = 32'h12345678;
        nxt();
        wr_req_valid  = 1'b0;
        rd0_req_valid = 1'b1;
        rd0_req_addr  = 18'h3;
        @(negedge CLK);
        check("t5_rd_grant", rd0_req_ready, 1);
        nxt();
        rd0_req_valid = 1'b0;
        wait_resp(1'b0, lat);
        check("t5_latency", lat, 3);
        check("t5_data", resp_data, 32'h12345678);
        nxt();
        drain(4);

        // Reset with two reads in flight, then a clean rd1 read
        do_reset();
        rd0_req_valid = 1'b1;
        rd0_req_addr  = 18'h50;
        rd1_req_valid = 1'b1;
        rd1_req_addr  = 18'h51;
        nxt();
        nxt();
        RST_N        = 1'b0;
        wr_req_valid = 1'b1;
        @(negedge CLK);
        check("t6_reset_outputs",
              {wr_req_ready, rd0_req_ready, rd1_req_ready, rd0_resp_valid, rd1_resp_valid,
               sram_rd_en, sram_wr_en, sram_dout_en}, 8'h00);
        nxt();
        RST_N = 1'b1;
        idle_inputs();
        repeat (5) nxt();
        rd1_req_valid = 1'b1;
        rd1_req_addr  = 18'h52;
        @(negedge CLK);
        check("t6_rd1_grant", rd1_req_ready, 1);
        nxt();
        rd1_req_valid = 1'b0;
        wait_resp(1'b1, lat);
        check("t6_latency", lat, 3);
        check("t6_data", resp_data, init_word('h52));
        nxt();
        drain(4);

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bit stall;
            stall          = ((c / 64) % 3 == 2);
            RST_N          = ($urandom_range(0, 399) != 0);
            wr_req_valid   = ($urandom_range(0, 99) < 45);
            wr_req_addr    = AW'($urandom_range(0, 15));
            wr_req_data    = $urandom;
            rd0_req_valid  = ($urandom_range(0, 99) < 55);
            rd0_req_addr   = AW'($urandom_range(0, 15));
            rd1_req_valid  = ($urandom_range(0, 99) < 55);
            rd1_req_addr   = AW'($urandom_range(0, 15));
            sram_rd_rdy    = ($urandom_range(0, 99) < 85);
            rd0_resp_ready = stall ? ($urandom_range(0, 99) < 10) : ($urandom_range(0, 99) < 75);
            rd1_resp_ready = ($urandom_range(0, 99) < 75);
            nxt();
        end
        RST_N = 1'b1;
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Upstream request stage for the ZBT SRAM controller in the frame-buffer path.
- Merges one write client (deblocking output) and two read clients (rd0: inter-prediction luma, rd1: chroma) onto the controller's single read/write request port.
- Tracks the owner of each outstanding read in a tag FIFO, then routes in-order read data from the controller back to the correct client.
- Guarantees the controller never sees a read and a write enable in the same cycle.

Parameters:
- addr_width, 18, SRAM word address width.
- data_width, 32, SRAM data width.
- TAG_DEPTH, 4, max outstanding reads; must be ≥ 4 (2-cycle SRAM pipeline + 2-entry response FIFO); power of 2.
- STARVE_LIMIT, 8, consecutive cycles a read may lose to writes before writes are blocked for one cycle.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset
- wr_req_valid  in  1  write request
- wr_req_addr  in  addr_width  write address
- wr_req_data  in  data_width  write data
- wr_req_ready  out  1  write accepted this cycle
- rd0_req_valid  in  1  client 0 read request
- rd0_req_addr  in  addr_width  client 0 address
- rd0_req_ready  out  1  client 0 read accepted
- rd0_resp_valid  out  1  client 0 data valid
- rd0_resp_ready  in  1  client 0 takes data
- rd1_req_valid  in  1  client 1 read request
- rd1_req_addr  in  addr_width  client 1 address
- rd1_req_ready  out  1  client 1 read accepted
- rd1_resp_valid  out  1  client 1 data valid
- rd1_resp_ready  in  1  client 1 takes data
- resp_data  out  data_width  read data, shared by both clients
- sram_rd_addr  out  addr_width  to controller RD_ADDR
- sram_rd_en  out  1  to controller RD_EN
- sram_rd_rdy  in  1  from controller RD_RDY
- sram_dout  in  data_width  from controller DOUT
- sram_dout_rdy  in  1  from controller DOUT_RDY
- sram_dout_en  out  1  to controller DOUT_EN
- sram_wr_addr  out  addr_width  to controller WR_ADDR
- sram_wr_val  out  data_width  to controller WR_VAL
- sram_wr_en  out  1  to controller WR_EN

Behaviour:
- Reset: RST_N is synchronous and active-low; clock is CLK.
  - While RST_N=0, all *_ready, *_resp_valid, sram_rd_en, sram_wr_en and sram_dout_en are forced 0.
  - State after reset: tag FIFO empty (count=0, pointers=0), starve_cnt=0, rr_last=1 (rd0 wins first tie).
  - Reset is shared with the SRAM controller. A mid-operation reset discards outstanding tags with no response delivered.
- Read eligibility: rd_ok = sram_rd_rdy & (tag_count < TAG_DEPTH) & (rd0_req_valid | rd1_req_valid).
- Grant is combinational, one per cycle:
  - force_rd = rd_ok & (starve_cnt == STARVE_LIMIT).
  - Write granted if wr_req_valid & ~force_rd.
  - Otherwise a read is granted if rd_ok.
- Read client select:
  - Only one client valid: that client.
  - Both valid: the client ≠ rr_last.
  - rr_last updates to the granted client on every read grant.
- Write grant: sram_wr_en=1, sram_wr_addr=wr_req_addr, sram_wr_val=wr_req_data, wr_req_ready=1, sram_rd_en=0. Zero-latency pass-through.
- Read grant:
  - sram_rd_en=1, sram_rd_addr = selected client address, selected rdX_req_ready=1.
  - Push tag (0/1) into tag FIFO at posedge.
- sram_rd_en and sram_wr_en are mutually exclusive in every cycle.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when rd_ok & write granted.
  - Cleared to 0 on any read grant, or when rd_ok=0.
- Response routing:
  - head = tag at FIFO read pointer.
  - rdX_resp_valid = sram_dout_rdy & (tag_count > 0) & (head == X); the other client's valid = 0.
  - resp_data = sram_dout.
  - sram_dout_en = valid & ready of the head client; the tag pops on the same edge.
  - A non-head client never receives data; the head client stalls the other (in-order return).
- Tag FIFO:
  - Simultaneous push and pop leaves count unchanged; pointers wrap modulo TAG_DEPTH.
  - Full blocks read grants only; writes continue.
  - Pop when empty must not occur. Assert in simulation if sram_dout_rdy=1 while count=0.
- Latency: a granted read returns data at the client no earlier than 3 cycles after grant, per controller pipeline. The arbiter adds 0 cycles.

Test Plan:
- Single rd0 read of addr 0x00010 with preloaded word 0xDEADBEEF → rd0_req_ready=1 in grant cycle; rd0_resp_valid=1 with resp_data=0xDEADBEEF 3 cycles later; rd1_resp_valid stays 0.
- rd0 and rd1 continuously valid, addrs 0x100 and 0x200 → grants alternate rd0,rd1,rd0,…; responses return to owners in issue order; no read/write enable overlap.
- wr_req_valid held high plus rd0 valid, STARVE_LIMIT=8 → 8 write grants, then 1 rd0 grant (wr_req_ready=0 that cycle), then writes resume; starve_cnt returns to 0.
- rd0_resp_ready=0 with 4 reads issued (2 rd0, 2 rd1) → tag_count reaches 4; further reads blocked while writes are still granted; releasing rd0_resp_ready drains rd0 then rd1 in order.
- Write 0x12345678 to 0x3 followed by a read of 0x3 → read returns 0x12345678.
- Assert RST_N=0 with 2 reads outstanding → all outputs 0 next cycle; tag_count=0 after release; a fresh rd1 read completes normally.
